instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory loader: the encoding counterpart of the core's instruction decode path. Accepts decoded instruction fields (kind, rd, rs1, rs2, immediate) over a valid/ready stream, packs them into 32-bit machine words using exactly the opcode/funct3/funct7/immediate layouts the core decodes, and writes them to consecutive instruction-memory addresses. It is used for boot-time program loading and for self-test program generation.

---
 rtl/instr_encoder_if.sv | 24 ++
 rtl/instr_encoder.sv | 95 +++++++++
 tb/tb_instr_encoder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle stream into the encoder and instruction-memory write port out of it
// master: bundle producer / memory (drives in_*, in_valid, mem_ack)
// slave:  encoder (drives in_ready, mem_we, mem_addr, mem_wdata)
interface instr_encoder_if #(parameter int ADDR_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [12:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field bundles into machine words and writes them to consecutive memory addresses
// clk/rst_n: clock, async active-low reset; start/base_addr/len: begin a load of len words at base_addr
// bus: valid/ready bundle stream in, mem_we/mem_addr/mem_wdata/mem_ack write port out
// busy: in RUN; done: one-cycle completion pulse; err: sticky illegal-bundle flag for the current load
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] waddr;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  acked;
    logic [3:0]        k;
    logic [12:0]       imm;
    logic              illegal;
    logic              xfer;
    logic              ack;
    logic [2:0]        r_f3;
    logic [2:0]        b_f3;
    logic [6:0]        r_f7;
    logic [31:0]       word;
    assign k    = bus.in_kind;
    assign imm  = bus.in_imm;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign bus.in_ready = state == RUN && issued < len_r && (!bus.mem_we || bus.mem_ack);
    assign xfer = bus.in_valid && bus.in_ready;
    assign ack  = bus.mem_we && bus.mem_ack;
    assign illegal = k > 4'd10
                  || ((k == 4'd5 || k == 4'd6 || k == 4'd7) && imm[12] != imm[11])
                  || (k >= 4'd8 && imm[0]);
    assign r_f3 = k == 4'd2 ? 3'b111 : k == 4'd3 ? 3'b110 : k == 4'd4 ? 3'b010 : 3'b000;
    assign r_f7 = k == 4'd1 ? 7'b0100000 : 7'b0000000;
    assign b_f3 = k == 4'd9 ? 3'b001 : k == 4'd10 ? 3'b100 : 3'b000;
    assign word = illegal     ? 32'h0000_0013
                : k <= 4'd4   ? {r_f7, bus.in_rs2, bus.in_rs1, r_f3, bus.in_rd, 7'b0110011}
                : k == 4'd5   ? {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011}
                : k == 4'd6   ? {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011}
                : k == 4'd7   ? {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011}
                :               {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, b_f3, imm[4:1], imm[11], 7'b1100011};
    // only one write is ever outstanding, so advancing the address per accepted bundle
    // yields the same sequence as advancing it per acknowledge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            waddr         <= '0;
            len_r         <= '0;
            issued        <= '0;
            acked         <= '0;
            err           <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    waddr  <= {base_addr[ADDR_W-1:2], 2'b00};
                    len_r  <= len;
                    issued <= '0;
                    acked  <= '0;
                    err    <= 1'b0;
                    state  <= len != '0 ? RUN : DONE;
                end
                RUN: begin
                    if (xfer) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= waddr;
                        bus.mem_wdata <= word;
                        waddr         <= waddr + ADDR_W'(4);
                        issued        <= issued + 1'b1;
                        err           <= err | illegal;
                    end else if (ack)
                        bus.mem_we <= 1'b0;
                    if (ack) begin
                        acked <= acked + 1'b1;
                        if (acked == len_r - 1'b1)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a write scoreboard for instr_encoder
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        err;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_addr = '0;
    logic [63:0] sb[$];
    logic [63:0] e;
    instr_encoder_if #(.ADDR_W(32)) bus ();
    instr_encoder #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .bus(bus.slave), .busy(busy), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", n, act, exp);
        end
    endtask
    task automatic chk1(input string n, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask
    // monitor: every acknowledged write must match the oldest expected word
    always @(negedge clk)
        if (rst_n && bus.mem_we && bus.mem_ack) begin
            chk1("write expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk32("mem_addr", bus.mem_addr, e[63:32]);
                chk32("mem_wdata", bus.mem_wdata, e[31:0]);
            end
        end
    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = b & ~32'd3;
    endtask
    task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm, input logic [31:0] w);
        logic got;
        got = 1'b0;
        bus.in_valid = 1'b1; bus.in_kind = k; bus.in_rd = rd;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
        sb.push_back({exp_addr, w});
        exp_addr += 32'd4;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!got) chk1("accept timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst in_ready", bus.in_ready, 1'b0);
        chk1("rst mem_we", bus.mem_we, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst err", err, 1'b0);
        chk32("rst mem_addr", bus.mem_addr, 32'h0);
        chk32("rst mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        // single ADD
        bus.mem_ack = 1'b1;
        do_start(32'h100, 16'd1);
        chk1("t1 busy", busy, 1'b1);
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3);
        chk1("t1 mem_we", bus.mem_we, 1'b1);
        chk32("t1 mem_addr", bus.mem_addr, 32'h100);
        @(posedge clk); #1;
        chk1("t1 done", done, 1'b1);
        chk1("t1 err", err, 1'b0);
        chk1("t1 busy low", busy, 1'b0);
        @(posedge clk); #1;
        chk1("t1 done pulse", done, 1'b0);
        // streaming SUB / SW / BEQ
        do_start(32'h100, 16'd3);
        send(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 32'h407302B3);
        send(4'd7, 5'd0, 5'd2, 5'd5, 13'd8, 32'h00512423);
        send(4'd8, 5'd0, 5'd1, 5'd2, 13'h1FFC, 32'hFE208EE3);
        @(posedge clk); #1;
        chk1("t2 done", done, 1'b1);
        // remaining kinds, immediate extremes, address wrap, unaligned base
        do_start(32'hFFFF_FFFA, 16'd6);
        send(4'd2, 5'd1, 5'd2, 5'd3, 13'd0, 32'h003170B3);
        send(4'd4, 5'd4, 5'd5, 5'd6, 13'd0, 32'h0062A233);
        send(4'd6, 5'd7, 5'd8, 5'd0, 13'h1FFC, 32'hFFC42383);
        send(4'd10, 5'd0, 5'd9, 5'd10, 13'h1800, 32'h80A4C0E3);
        send(4'd5, 5'd1, 5'd0, 5'd0, 13'h1FFF, 32'hFFF00093);
        send(4'd5, 5'd1, 5'd0, 5'd0, 13'h07FF, 32'h7FF00093);
        @(posedge clk); #1;
        chk1("t3 done", done, 1'b1);
        chk1("t3 err", err, 1'b0);
        // memory stall
        bus.mem_ack = 1'b0;
        do_start(32'h200, 16'd2);
        send(4'd5, 5'd1, 5'd0, 5'd0, 13'd5, 32'h00500093);
        bus.in_valid = 1'b1; bus.in_kind = 4'd3; bus.in_rd = 5'd4;
        bus.in_rs1 = 5'd5; bus.in_rs2 = 5'd6; bus.in_imm = 13'd0;
        sb.push_back({exp_addr, 32'h0062E233});
        exp_addr += 32'd4;
        repeat (3) begin
            @(negedge clk);
            chk1("stall mem_we", bus.mem_we, 1'b1);
            chk32("stall mem_addr", bus.mem_addr, 32'h200);
            chk32("stall mem_wdata", bus.mem_wdata, 32'h00500093);
            chk1("stall in_ready", bus.in_ready, 1'b0);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk1("ack in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk32("t4 next addr", bus.mem_addr, 32'h204);
        chk32("t4 next word", bus.mem_wdata, 32'h0062E233);
        @(posedge clk); #1;
        chk1("t4 done", done, 1'b1);
        // illegal bundles
        do_start(32'h300, 16'd3);
        chk1("t5 err clear", err, 1'b0);
        send(4'd12, 5'd1, 5'd2, 5'd3, 13'd0, 32'h00000013);
        send(4'd5, 5'd1, 5'd2, 5'd0, 13'h0800, 32'h00000013);
        send(4'd8, 5'd0, 5'd1, 5'd2, 13'd3, 32'h00000013);
        @(posedge clk); #1;
        chk1("t5 done", done, 1'b1);
        chk1("t5 err", err, 1'b1);
        @(posedge clk); #1;
        chk1("t5 err sticky", err, 1'b1);
        // zero length
        do_start(32'h400, 16'd0);
        chk1("t6 done", done, 1'b1);
        chk1("t6 busy", busy, 1'b0);
        chk1("t6 mem_we", bus.mem_we, 1'b0);
        chk1("t6 err cleared", err, 1'b0);
        @(posedge clk); #1;
        chk1("t6 done pulse", done, 1'b0);
        // start during RUN is ignored
        do_start(32'h500, 16'd1);
        start = 1'b1; base_addr = 32'h600; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk1("t6 still busy", busy, 1'b1);
        send(4'd9, 5'd0, 5'd1, 5'd2, 13'd8, 32'h00209463);
        @(posedge clk); #1;
        chk1("t6 len kept", done, 1'b1);
        // async reset mid-load
        bus.mem_ack = 1'b0;
        do_start(32'h700, 16'd2);
        send(4'd6, 5'd7, 5'd8, 5'd0, 13'd4, 32'h00442383);
        chk1("t7 pending", bus.mem_we, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1("t7 reset mem_we", bus.mem_we, 1'b0);
        chk1("t7 reset busy", busy, 1'b0);
        chk1("t7 reset in_ready", bus.in_ready, 1'b0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        do_start(32'h800, 16'd1);
        send(4'd0, 5'd1, 5'd1, 5'd1, 13'd0, 32'h001080B3);
        @(posedge clk); #1;
        chk1("t7 done", done, 1'b1);
        @(posedge clk); #1;
        chk1("scoreboard drained", sb.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
